// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: after global reset release, turns on the domain clock
// gates, then releases each domain reset in index order. The next domain is
// released only after the previous one acknowledges and a spacing delay
// elapses. Detects domains that never acknowledge (timeout) or that drop
// their acknowledgement once the sequence is done, and supports a software
// requested re-sequence from DONE or ERR.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int DLY_WIDTH   = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DLY_WIDTH-1:0]   DLY_CFG,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic                   CLK_GATE_EN,
    output logic                   SEQ_DONE,
    output logic                   SEQ_ERR
);

    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_CLK_ON   = 3'd1;
    localparam logic [2:0] S_RELEASE  = 3'd2;
    localparam logic [2:0] S_SPACE    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;
    localparam logic [2:0] S_REASSERT = 3'd6;

    logic [2:0]           state;
    logic [DLY_WIDTH-1:0] cnt;
    logic [TCNT_W-1:0]    tcnt;
    logic [IDX_W-1:0]     idx;
    logic [DLY_WIDTH-1:0] dly_ld;

    // A programmed delay of zero still spaces events by one edge.
    assign dly_ld = (DLY_CFG == '0) ? DLY_WIDTH'(1) : DLY_CFG;

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_HOLD;
            cnt          <= '0;
            tcnt         <= '0;
            idx          <= '0;
            DOMAIN_RST_N <= '0;
            CLK_GATE_EN  <= 1'b0;
            SEQ_DONE     <= 1'b0;
            SEQ_ERR      <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    CLK_GATE_EN <= 1'b1;
                    cnt         <= dly_ld;
                    state       <= S_CLK_ON;
                end

                // All three countdown states release domain idx on expiry;
                // idx is 0 in CLK_ON and REASSERT.
                S_CLK_ON, S_SPACE, S_REASSERT: begin
                    if (cnt <= DLY_WIDTH'(1)) begin
                        cnt               <= '0;
                        tcnt              <= '0;
                        DOMAIN_RST_N[idx] <= 1'b1;
                        state             <= S_RELEASE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (DOMAIN_ACK[idx]) begin
                        tcnt <= '0;
                        if (idx == LAST_IDX) begin
                            SEQ_DONE <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            cnt   <= dly_ld;
                            state <= S_SPACE;
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        DOMAIN_RST_N <= '0;
                        SEQ_DONE     <= 1'b0;
                        SEQ_ERR      <= 1'b1;
                        state        <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                // Software request beats a simultaneous loss of acknowledge.
                S_DONE: begin
                    if (SW_RST_REQ) begin
                        DOMAIN_RST_N <= '0;
                        SEQ_DONE     <= 1'b0;
                        SEQ_ERR      <= 1'b0;
                        idx          <= '0;
                        cnt          <= dly_ld;
                        state        <= S_REASSERT;
                    end else if (!(&DOMAIN_ACK)) begin
                        DOMAIN_RST_N <= '0;
                        SEQ_DONE     <= 1'b0;
                        SEQ_ERR      <= 1'b1;
                        state        <= S_ERR;
                    end
                end

                S_ERR: begin
                    if (SW_RST_REQ) begin
                        DOMAIN_RST_N <= '0;
                        SEQ_DONE     <= 1'b0;
                        SEQ_ERR      <= 1'b0;
                        idx          <= '0;
                        cnt          <= dly_ld;
                        state        <= S_REASSERT;
                    end
                end

                default: state <= S_HOLD;
            endcase
        end
    end

endmodule
